// File: rtl/snn_spike_readout.sv
// snn_spike_readout: counts per-neuron spikes over a fixed window of core timesteps,
// then serially scans the counters to report the winning neuron, its count, a tie flag and an all-zero flag.
module snn_spike_readout #(
  parameter int N = 96,
  parameter int T_STEPS = 100,
  parameter int CW = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int SW = $clog2(T_STEPS + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          clear,
  input  logic          step_valid,
  input  logic [N-1:0]  spikes_vec,
  input  logic          out_ready,
  output logic          busy,
  output logic          out_valid,
  output logic [IW-1:0] out_class,
  output logic [CW-1:0] out_count,
  output logic          out_tie,
  output logic          out_zero
);
  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;
  state_t               state_q;
  logic [N-1:0][CW-1:0] cnt_q;
  logic [SW-1:0]        step_q;
  logic [IW-1:0]        i_q, idx_q, idx_d, cls_q;
  logic [CW-1:0]        best_q, best_d, cur_d, res_cnt_q;
  logic                 tie_q, tie_d, first_d, gt_d, busy_q, valid_q, res_tie_q, res_zero_q;
  // One counter per cycle through a mux; strict greater-than keeps the lowest index on ties.
  always_comb begin
    cur_d   = cnt_q[i_q];
    first_d = i_q == '0;
    gt_d    = cur_d > best_q;
    best_d  = (first_d || gt_d) ? cur_d : best_q;
    idx_d   = (first_d || gt_d) ? i_q : idx_q;
    tie_d   = (first_d || gt_d) ? 1'b0 : (cur_d == best_q) ? 1'b1 : tie_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      step_q     <= '0;
      i_q        <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      tie_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      cls_q      <= '0;
      res_cnt_q  <= '0;
      res_tie_q  <= 1'b0;
      res_zero_q <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          cnt_q   <= '0;
          step_q  <= '0;
          state_q <= ACCUM;
          busy_q  <= 1'b1;
        end
        ACCUM: if (step_valid) begin
          for (int n = 0; n < N; n++)
            if (spikes_vec[n] && cnt_q[n] != {CW{1'b1}}) cnt_q[n] <= cnt_q[n] + 1'b1;
          step_q <= step_q + 1'b1;
          if (step_q == SW'(T_STEPS - 1)) begin
            state_q <= SCAN;
            i_q     <= '0;
          end
        end
        SCAN: begin
          best_q <= best_d;
          idx_q  <= idx_d;
          tie_q  <= tie_d;
          i_q    <= i_q + 1'b1;
          if (i_q == IW'(N - 1)) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            valid_q    <= 1'b1;
            cls_q      <= idx_d;
            res_cnt_q  <= best_d;
            res_tie_q  <= tie_d;
            res_zero_q <= best_d == '0;
          end
        end
        DONE: if (out_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_class = cls_q;
  assign out_count = res_cnt_q;
  assign out_tie   = res_tie_q;
  assign out_zero  = res_zero_q;
endmodule

// File: tb/tb_snn_spike_readout.sv
// tb_snn_spike_readout: two readouts (4-step and 10-step windows) share one random/directed stimulus
// and are checked every cycle against a window-level model of the counting and winner rules.
module tb_snn_spike_readout;
  localparam int N = 4;
  localparam int CW = 3;
  localparam int MAXC = 7;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, clear = 1'b0, step_valid = 1'b0, out_ready = 1'b0;
  logic [N-1:0] spikes_vec = '0;
  logic [1:0] busy, out_valid, out_tie, out_zero;
  logic [1:0] out_class [2];
  logic [2:0] out_count [2];
  int checks = 0, passes = 0, k;
  snn_spike_readout #(.N(N), .T_STEPS(4), .CW(CW)) dut0 (
    .clk(clk), .rstn(rstn), .start(start), .clear(clear), .step_valid(step_valid),
    .spikes_vec(spikes_vec), .out_ready(out_ready), .busy(busy[0]), .out_valid(out_valid[0]),
    .out_class(out_class[0]), .out_count(out_count[0]), .out_tie(out_tie[0]), .out_zero(out_zero[0]));
  snn_spike_readout #(.N(N), .T_STEPS(10), .CW(CW)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .clear(clear), .step_valid(step_valid),
    .spikes_vec(spikes_vec), .out_ready(out_ready), .busy(busy[1]), .out_valid(out_valid[1]),
    .out_class(out_class[1]), .out_count(out_count[1]), .out_tie(out_tie[1]), .out_zero(out_zero[1]));
  always #5 clk = ~clk;
  // Model: mode 0 idle, 1 accumulating, 2 waiting out the N-cycle scan, 3 result held.
  int m_cnt [2][N];
  int m_steps [2], m_mode [2], m_left [2];
  int p_cls [2], p_cnt [2], p_tie [2], p_zero [2];
  int e_cls [2], e_cnt [2], e_tie [2], e_zero [2];
  function automatic int tsteps(input int m);
    return (m == 0) ? 4 : 10;
  endfunction
  function automatic void resolve(input int m);
    int best, ties;
    best = 0;
    for (int j = 0; j < N; j++) if (m_cnt[m][j] > best) best = m_cnt[m][j];
    p_cls[m] = -1;
    ties = 0;
    for (int j = 0; j < N; j++)
      if (m_cnt[m][j] == best) begin
        if (p_cls[m] < 0) p_cls[m] = j;
        ties++;
      end
    p_cnt[m]  = best;
    p_tie[m]  = (ties > 1) ? 1 : 0;
    p_zero[m] = (best == 0) ? 1 : 0;
  endfunction
  always @(posedge clk or negedge rstn) begin
    for (int m = 0; m < 2; m++) begin
      if (!rstn) begin
        m_mode[m] = 0; m_steps[m] = 0; m_left[m] = 0;
        for (int j = 0; j < N; j++) m_cnt[m][j] = 0;
        e_cls[m] = 0; e_cnt[m] = 0; e_tie[m] = 0; e_zero[m] = 0;
      end else if (clear) m_mode[m] = 0;
      else if (m_mode[m] == 0) begin
        if (start) begin
          for (int j = 0; j < N; j++) m_cnt[m][j] = 0;
          m_steps[m] = 0;
          m_mode[m] = 1;
        end
      end else if (m_mode[m] == 1) begin
        if (step_valid) begin
          for (int j = 0; j < N; j++) if (spikes_vec[j] && m_cnt[m][j] < MAXC) m_cnt[m][j]++;
          m_steps[m]++;
          if (m_steps[m] == tsteps(m)) begin
            resolve(m);
            m_left[m] = N;
            m_mode[m] = 2;
          end
        end
      end else if (m_mode[m] == 2) begin
        m_left[m]--;
        if (m_left[m] == 0) begin
          m_mode[m] = 3;
          e_cls[m] = p_cls[m]; e_cnt[m] = p_cnt[m]; e_tie[m] = p_tie[m]; e_zero[m] = p_zero[m];
        end
      end else if (out_ready) m_mode[m] = 0;
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("busy%0d", m), int'(busy[m]), (m_mode[m] == 1 || m_mode[m] == 2) ? 1 : 0);
      chk($sformatf("valid%0d", m), int'(out_valid[m]), (m_mode[m] == 3) ? 1 : 0);
      chk($sformatf("class%0d", m), int'(out_class[m]), e_cls[m]);
      chk($sformatf("count%0d", m), int'(out_count[m]), e_cnt[m]);
      chk($sformatf("tie%0d", m), int'(out_tie[m]), e_tie[m]);
      chk($sformatf("zero%0d", m), int'(out_zero[m]), e_zero[m]);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic begin_win();
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
  endtask
  task automatic steps(input logic [N-1:0] v, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      step_valid = 1'b1; spikes_vec = v; tick();
      if (gaps) begin
        step_valid = 1'b0; spikes_vec = '1; tick();
      end
    end
    step_valid = 1'b0; spikes_vec = '0;
  endtask
  task automatic wait_valid(input int m, output int n);
    n = 0;
    while (!out_valid[m] && n < 64) begin
      tick();
      n++;
    end
    chk("valid_reached", int'(out_valid[m]), 1);
  endtask
  task automatic expect_res(input string tag, input int m, input int cls, input int cnt, input int tie, input int zero);
    chk({tag, "_class"}, int'(out_class[m]), cls);
    chk({tag, "_count"}, int'(out_count[m]), cnt);
    chk({tag, "_tie"}, int'(out_tie[m]), tie);
    chk({tag, "_zero"}, int'(out_zero[m]), zero);
  endtask
  task automatic release_res();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask
  initial begin
    tick();
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_valid", int'(out_valid[0]), 0);
    expect_res("reset", 0, 0, 0, 0, 0);
    rstn = 1'b1;
    tick();
    begin_win();
    steps(4'b0100, 4, 1'b0);
    wait_valid(0, k);
    chk("basic_latency", k + 1, 5);
    expect_res("basic", 0, 2, 4, 0, 0);
    out_ready = 1'b1; start = 1'b1; tick(); out_ready = 1'b0; start = 1'b0;
    chk("ready_start_ignored", int'(busy[0]), 0);
    chk("ready_to_idle", int'(out_valid[0]), 0);
    begin_win();
    steps(4'b1010, 4, 1'b0);
    wait_valid(0, k);
    expect_res("tie", 0, 1, 4, 1, 0);
    release_res();
    begin_win();
    steps(4'b0001, 10, 1'b0);
    wait_valid(1, k);
    expect_res("sat", 1, 0, 7, 0, 0);
    release_res();
    begin_win();
    steps(4'b0011, 4, 1'b1);
    wait_valid(0, k);
    expect_res("gap", 0, 0, 4, 1, 0);
    repeat (20) tick();
    expect_res("hold", 0, 0, 4, 1, 0);
    release_res();
    chk("bp_idle", int'(out_valid[0]), 0);
    begin_win();
    steps(4'b1000, 2, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("abort_busy", int'(busy[0]), 0);
    start = 1'b1; tick(); start = 1'b0;
    steps(4'b1100, 4, 1'b0);
    wait_valid(0, k);
    expect_res("abort", 0, 2, 4, 1, 0);
    release_res();
    begin_win();
    steps(4'b0000, 4, 1'b0);
    wait_valid(0, k);
    expect_res("allzero", 0, 0, 0, 1, 1);
    release_res();
    begin_win();
    steps(4'b0100, 4, 1'b0);
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("areset_busy0", int'(busy[0]), 0);
    chk("areset_busy1", int'(busy[1]), 0);
    chk("areset_valid0", int'(out_valid[0]), 0);
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("post_reset_idle", int'(busy[0]), 0);
    start = 1'b1; tick(); start = 1'b0;
    steps(4'b0010, 4, 1'b0);
    wait_valid(0, k);
    expect_res("after_reset", 0, 1, 4, 0, 0);
    release_res();
    for (int i = 0; i < 3000; i++) begin
      start      = $urandom_range(0, 3) == 0;
      clear      = $urandom_range(0, 63) == 0;
      step_valid = $urandom_range(0, 3) != 0;
      spikes_vec = N'($urandom);
      out_ready  = $urandom_range(0, 2) == 0;
      tick();
    end
    start = 1'b0; clear = 1'b0; step_valid = 1'b0; out_ready = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
